branch_rs: RTL and testbench
============================

# branch_rs

Reservation station for conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in the out-of-order core. Holds issued branches until both source operands are available, snoops the two CDB result buses for pending operands, and dispatches one ready branch per cycle to the branch ALU, which resolves taken/not-taken and the next PC. Sits between the issue/decode stage and the branch ALU; flushed on misprediction.

## Interface
- RS_SIZE, 8: number of entries (power of two, ≥2)
- ROB_BIT, 4: ROB index width
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low = pause (all state holds)
- clear_in  in  1  misprediction flush
- issue_valid  in  1  new branch presented this cycle
- issue_op  in  3  funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
- issue_imm  in  12  branch offset bits [12:1]
- issue_pc  in  32  branch PC
- issue_rob_entry  in  ROB_BIT  ROB tag of the branch
- issue_qi_valid / issue_qj_valid  in  1  rs1 / rs2 still pending
- issue_qi / issue_qj  in  ROB_BIT  producer tag for rs1 / rs2
- issue_vi / issue_vj  in  32  rs1 / rs2 value (meaningful when not pending)
- cdb_alu_valid, cdb_alu_rob, cdb_alu_val  in  1/ROB_BIT/32  ALU result broadcast
- cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val  in  1/ROB_BIT/32  load result broadcast
- full  out  1  no free entry (combinational from current occupancy)
- alu_valid  out  1  dispatch strobe to branch ALU
- alu_vi, alu_vj  out  32  operand values
- alu_imm  out  12  offset [12:1]
- alu_op  out  3  funct3
- alu_pc  out  32  branch PC
- alu_rob_entry  out  ROB_BIT  ROB tag

## Operation
- Per entry: busy, op, imm, pc, rob, vi, vj, qi_valid, qi, qj_valid, qj.
- Priority at each posedge: reset (rst_in==0) > pause (rdy_in==0) > clear_in > normal.
- Reset: all busy=0; alu_valid=0; alu_vi/vj/imm/op/pc/rob_entry=0; full=0.
- Pause: every register holds, including alu_valid and all alu_* outputs.
- clear_in: all busy=0, alu_valid=0, issue ignored, CDB ignored that edge.
- Issue: if issue_valid && !full, write lowest-index non-busy entry. Issue with full=1 is an upstream protocol violation; entry is dropped, state unchanged.
- Issue bypass: if issue_qi_valid and a CDB bus valid in the same cycle carries issue_qi, store that value with qi_valid=0 (same for qj). ALU bus checked first; if both buses carry the tag, values are equal by construction.
- Wakeup: each busy entry with qi_valid==1 and a valid CDB tag match captures the value and clears qi_valid; independently for qj; both operands may wake on the same edge from different buses.
- Select: ready = busy && !qi_valid && !qj_valid, evaluated on current (pre-edge) state. Lowest-index ready entry dispatches: its fields load into alu_*, alu_valid<=1, entry busy<=0. No ready entry: alu_valid<=0, alu_* hold previous values.
- One dispatch per cycle maximum. A freed entry is reusable by an issue at the next edge, not the same edge.
- full = (count of busy entries == RS_SIZE); reflects current state only, no look-ahead on same-cycle dispatch.

## Timing
- Issue with both operands ready at edge N: entry busy after N; dispatched at edge N+1; alu_valid high during cycle N+1..N+2. Minimum issue-to-ALU latency: 2 edges.
- Issue bypass counts as ready at insertion (same latency as above).
- CDB wakeup at edge N: entry selectable in cycle after N, dispatched at N+1.
- alu_valid is a one-cycle pulse per dispatch (except held across pause); back-to-back dispatches keep it high on consecutive cycles with new data.
- Full boundary: with RS_SIZE entries busy, full=1; a dispatch at edge N lowers full after N.
- Reset or clear_in mid-operation: effective at that edge; no dispatch emerges afterward from pre-flush entries.

## Test plan
- Reset: hold rst_in=0 two cycles -> alu_valid=0, full=0, all alu_*=0; release, no activity -> alu_valid stays 0.
- Ready issue: issue BEQ pc=0x100, imm=0x004, vi=vj=5, rob=3 at edge N -> at N+1 alu_valid=1, alu_pc=0x100, alu_op=000, alu_vi=alu_vj=5, alu_rob_entry=3; next cycle alu_valid=0.
- Wakeup: issue BLT qi_valid=1 qi=7, vj=10; CDB lsb rob=7 val=0xFFFFFFFF two cycles later -> dispatch one edge after broadcast, alu_vi=0xFFFFFFFF; also same-cycle bypass case dispatches at N+1.
- Fill: issue 8 branches all pending on tag 2 -> full=1 after 8th; 9th issue ignored; CDB alu rob=2 -> entries dispatch in index order 0..7 on 8 consecutive cycles, full drops after first dispatch.
- Flush: 3 pending + 1 ready entries, assert clear_in on dispatch edge -> alu_valid=0, full=0, later CDB matches produce no dispatch.
- Pause: rdy_in=0 while alu_valid=1 -> alu_* and alu_valid hold, CDB ignored; resume -> normal sequencing continues.

Source files
------------

// File: rtl/branch_rs.sv
// Reservation station for conditional branches: holds issued branches until both
// operands arrive (via issue, bypass or CDB snoop) and dispatches one ready entry per cycle.
module branch_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic               issue_valid,
    input  logic [2:0]         issue_op,
    input  logic [11:0]        issue_imm,
    input  logic [31:0]        issue_pc,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               issue_qi_valid,
    input  logic               issue_qj_valid,
    input  logic [ROB_BIT-1:0] issue_qi,
    input  logic [ROB_BIT-1:0] issue_qj,
    input  logic [31:0]        issue_vi,
    input  logic [31:0]        issue_vj,
    input  logic               cdb_alu_valid,
    input  logic [ROB_BIT-1:0] cdb_alu_rob,
    input  logic [31:0]        cdb_alu_val,
    input  logic               cdb_lsb_valid,
    input  logic [ROB_BIT-1:0] cdb_lsb_rob,
    input  logic [31:0]        cdb_lsb_val,
    output logic               full,
    output logic               alu_valid,
    output logic [31:0]        alu_vi,
    output logic [31:0]        alu_vj,
    output logic [11:0]        alu_imm,
    output logic [2:0]         alu_op,
    output logic [31:0]        alu_pc,
    output logic [ROB_BIT-1:0] alu_rob_entry
);

    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qi_valid_q, qi_valid_d;
    logic [RS_SIZE-1:0] qj_valid_q, qj_valid_d;
    logic [2:0]         op_q  [RS_SIZE];
    logic [2:0]         op_d  [RS_SIZE];
    logic [11:0]        imm_q [RS_SIZE];
    logic [11:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];
    logic [ROB_BIT-1:0] rob_q [RS_SIZE];
    logic [ROB_BIT-1:0] rob_d [RS_SIZE];
    logic [31:0]        vi_q  [RS_SIZE];
    logic [31:0]        vi_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [ROB_BIT-1:0] qi_q  [RS_SIZE];
    logic [ROB_BIT-1:0] qi_d  [RS_SIZE];
    logic [ROB_BIT-1:0] qj_q  [RS_SIZE];
    logic [ROB_BIT-1:0] qj_d  [RS_SIZE];

    logic               alu_valid_q, alu_valid_d;
    logic [31:0]        alu_vi_q, alu_vi_d;
    logic [31:0]        alu_vj_q, alu_vj_d;
    logic [11:0]        alu_imm_q, alu_imm_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [31:0]        alu_pc_q, alu_pc_d;
    logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

    logic [RS_SIZE-1:0] ready;
    logic [IdxW-1:0]    free_idx, sel_idx;
    logic               sel_found;
    logic               new_qi_pend, new_qj_pend;
    logic [31:0]        new_vi, new_vj;

    assign full = &busy_q;

    // Descending scan so the lowest index wins for both free slot and dispatch pick.
    always_comb begin
        ready     = busy_q & ~qi_valid_q & ~qj_valid_q;
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IdxW'(i);
            if (ready[i]) begin
                sel_idx   = IdxW'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Same-cycle CDB bypass for the incoming branch; ALU bus takes precedence.
    always_comb begin
        new_qi_pend = issue_qi_valid;
        new_vi      = issue_vi;
        if (issue_qi_valid && cdb_alu_valid && cdb_alu_rob == issue_qi) begin
            new_qi_pend = 1'b0;
            new_vi      = cdb_alu_val;
        end else if (issue_qi_valid && cdb_lsb_valid && cdb_lsb_rob == issue_qi) begin
            new_qi_pend = 1'b0;
            new_vi      = cdb_lsb_val;
        end
        new_qj_pend = issue_qj_valid;
        new_vj      = issue_vj;
        if (issue_qj_valid && cdb_alu_valid && cdb_alu_rob == issue_qj) begin
            new_qj_pend = 1'b0;
            new_vj      = cdb_alu_val;
        end else if (issue_qj_valid && cdb_lsb_valid && cdb_lsb_rob == issue_qj) begin
            new_qj_pend = 1'b0;
            new_vj      = cdb_lsb_val;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        qi_valid_d = qi_valid_q;
        qj_valid_d = qj_valid_q;
        op_d       = op_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rob_d      = rob_q;
        vi_d       = vi_q;
        vj_d       = vj_q;
        qi_d       = qi_q;
        qj_d       = qj_q;
        alu_valid_d = 1'b0;
        alu_vi_d    = alu_vi_q;
        alu_vj_d    = alu_vj_q;
        alu_imm_d   = alu_imm_q;
        alu_op_d    = alu_op_q;
        alu_pc_d    = alu_pc_q;
        alu_rob_d   = alu_rob_q;

        if (clear_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qi_valid_q[i]) begin
                    if (cdb_alu_valid && cdb_alu_rob == qi_q[i]) begin
                        vi_d[i]       = cdb_alu_val;
                        qi_valid_d[i] = 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_rob == qi_q[i]) begin
                        vi_d[i]       = cdb_lsb_val;
                        qi_valid_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qj_valid_q[i]) begin
                    if (cdb_alu_valid && cdb_alu_rob == qj_q[i]) begin
                        vj_d[i]       = cdb_alu_val;
                        qj_valid_d[i] = 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_rob == qj_q[i]) begin
                        vj_d[i]       = cdb_lsb_val;
                        qj_valid_d[i] = 1'b0;
                    end
                end
            end

            if (sel_found) begin
                alu_valid_d     = 1'b1;
                alu_vi_d        = vi_q[sel_idx];
                alu_vj_d        = vj_q[sel_idx];
                alu_imm_d       = imm_q[sel_idx];
                alu_op_d        = op_q[sel_idx];
                alu_pc_d        = pc_q[sel_idx];
                alu_rob_d       = rob_q[sel_idx];
                busy_d[sel_idx] = 1'b0;
            end

            // free_idx comes from pre-edge busy, so a slot freed this edge is never reused here.
            if (issue_valid && !full) begin
                busy_d[free_idx]     = 1'b1;
                op_d[free_idx]       = issue_op;
                imm_d[free_idx]      = issue_imm;
                pc_d[free_idx]       = issue_pc;
                rob_d[free_idx]      = issue_rob_entry;
                qi_valid_d[free_idx] = new_qi_pend;
                qj_valid_d[free_idx] = new_qj_pend;
                qi_d[free_idx]       = issue_qi;
                qj_d[free_idx]       = issue_qj;
                vi_d[free_idx]       = new_vi;
                vj_d[free_idx]       = new_vj;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_vi_q    <= '0;
            alu_vj_q    <= '0;
            alu_imm_q   <= '0;
            alu_op_q    <= '0;
            alu_pc_q    <= '0;
            alu_rob_q   <= '0;
        end else if (rdy_in) begin
            busy_q      <= busy_d;
            alu_valid_q <= alu_valid_d;
            alu_vi_q    <= alu_vi_d;
            alu_vj_q    <= alu_vj_d;
            alu_imm_q   <= alu_imm_d;
            alu_op_q    <= alu_op_d;
            alu_pc_q    <= alu_pc_d;
            alu_rob_q   <= alu_rob_d;
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            qi_valid_q <= qi_valid_d;
            qj_valid_q <= qj_valid_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rob_q      <= rob_d;
            vi_q       <= vi_d;
            vj_q       <= vj_d;
            qi_q       <= qi_d;
            qj_q       <= qj_d;
        end
    end

    assign alu_valid     = alu_valid_q;
    assign alu_vi        = alu_vi_q;
    assign alu_vj        = alu_vj_q;
    assign alu_imm       = alu_imm_q;
    assign alu_op        = alu_op_q;
    assign alu_pc        = alu_pc_q;
    assign alu_rob_entry = alu_rob_q;

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: a slot-list reference model predicts the outputs after
// every clock edge; a negedge monitor pops each prediction and compares.
module tb_branch_rs;

    localparam int RS = 8;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_in;
    logic          issue_valid;
    logic [2:0]    issue_op;
    logic [11:0]   issue_imm;
    logic [31:0]   issue_pc;
    logic [RB-1:0] issue_rob_entry;
    logic          issue_qi_valid, issue_qj_valid;
    logic [RB-1:0] issue_qi, issue_qj;
    logic [31:0]   issue_vi, issue_vj;
    logic          cdb_alu_valid, cdb_lsb_valid;
    logic [RB-1:0] cdb_alu_rob, cdb_lsb_rob;
    logic [31:0]   cdb_alu_val, cdb_lsb_val;
    logic          full, alu_valid;
    logic [31:0]   alu_vi, alu_vj, alu_pc;
    logic [11:0]   alu_imm;
    logic [2:0]    alu_op;
    logic [RB-1:0] alu_rob_entry;

    always #5 clk_in = ~clk_in;

    branch_rs #(.RS_SIZE(RS), .ROB_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_rob_entry(issue_rob_entry),
        .issue_qi_valid(issue_qi_valid), .issue_qj_valid(issue_qj_valid),
        .issue_qi(issue_qi), .issue_qj(issue_qj), .issue_vi(issue_vi), .issue_vj(issue_vj),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
        .full(full), .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj),
        .alu_imm(alu_imm), .alu_op(alu_op), .alu_pc(alu_pc), .alu_rob_entry(alu_rob_entry)
    );

    typedef struct {
        bit          busy;
        logic [2:0]  op;
        logic [11:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic [31:0] vi, vj;
        bit          qiv, qjv;
        logic [3:0]  qi, qj;
    } slot_t;

    typedef struct {
        bit          valid;
        bit          full;
        logic [31:0] vi, vj, pc;
        logic [11:0] imm;
        logic [2:0]  op;
        logic [3:0]  rob;
    } out_t;

    slot_t m[RS];
    out_t  mo;
    out_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] v);
        v = '0;
        if (cdb_alu_valid && cdb_alu_rob == tag) begin
            v = cdb_alu_val;
            return 1'b1;
        end
        if (cdb_lsb_valid && cdb_lsb_rob == tag) begin
            v = cdb_lsb_val;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Predict the effect of the coming edge from the current inputs and pre-edge model.
    task automatic model_edge();
        slot_t       nm[RS];
        int          pick, free;
        logic [31:0] v;
        if (!rst_in) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            mo = '{default: 0};
        end else if (!rdy_in) begin
        end else if (clear_in) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            mo.valid = 1'b0;
        end else begin
            nm   = m;
            pick = -1;
            free = -1;
            for (int i = 0; i < RS; i++) begin
                if (pick < 0 && m[i].busy && !m[i].qiv && !m[i].qjv) pick = i;
                if (free < 0 && !m[i].busy) free = i;
            end
            for (int i = 0; i < RS; i++) begin
                if (m[i].busy && m[i].qiv && cdb_hit(m[i].qi, v)) begin
                    nm[i].vi = v; nm[i].qiv = 1'b0;
                end
                if (m[i].busy && m[i].qjv && cdb_hit(m[i].qj, v)) begin
                    nm[i].vj = v; nm[i].qjv = 1'b0;
                end
            end
            mo.valid = (pick >= 0);
            if (pick >= 0) begin
                mo.vi = m[pick].vi; mo.vj = m[pick].vj; mo.pc = m[pick].pc;
                mo.imm = m[pick].imm; mo.op = m[pick].op; mo.rob = m[pick].rob;
                nm[pick].busy = 1'b0;
            end
            if (issue_valid && free >= 0) begin
                nm[free].busy = 1'b1;
                nm[free].op = issue_op; nm[free].imm = issue_imm; nm[free].pc = issue_pc;
                nm[free].rob = issue_rob_entry;
                nm[free].qi = issue_qi; nm[free].qj = issue_qj;
                nm[free].vi = issue_vi; nm[free].vj = issue_vj;
                nm[free].qiv = issue_qi_valid; nm[free].qjv = issue_qj_valid;
                if (issue_qi_valid && cdb_hit(issue_qi, v)) begin
                    nm[free].vi = v; nm[free].qiv = 1'b0;
                end
                if (issue_qj_valid && cdb_hit(issue_qj, v)) begin
                    nm[free].vj = v; nm[free].qjv = 1'b0;
                end
            end
            m = nm;
        end
        mo.full = model_full();
        exp_q.push_back(mo);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        issue_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0; clear_in = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] imm,
                         input logic [3:0] rob, input bit qiv, input logic [3:0] qi,
                         input logic [31:0] vi, input bit qjv, input logic [3:0] qj,
                         input logic [31:0] vj);
        issue_valid = 1; issue_op = op; issue_pc = pc; issue_imm = imm; issue_rob_entry = rob;
        issue_qi_valid = qiv; issue_qi = qi; issue_vi = vi;
        issue_qj_valid = qjv; issue_qj = qj; issue_vj = vj;
    endtask

    task automatic rand_cdb();
        cdb_alu_valid = ($urandom_range(0, 9) < 4);
        cdb_lsb_valid = ($urandom_range(0, 9) < 4);
        cdb_alu_rob = 4'($urandom_range(0, 7));
        cdb_lsb_rob = 4'($urandom_range(0, 7));
        cdb_alu_val = $urandom;
        cdb_lsb_val = $urandom;
        if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_rob == cdb_lsb_rob)
            cdb_lsb_val = cdb_alu_val;
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alu_valid", 32'(alu_valid), 32'(e.valid));
                check("full", 32'(full), 32'(e.full));
                check("alu_vi", alu_vi, e.vi);
                check("alu_vj", alu_vj, e.vj);
                check("alu_pc", alu_pc, e.pc);
                check("alu_imm", 32'(alu_imm), 32'(e.imm));
                check("alu_op", 32'(alu_op), 32'(e.op));
                check("alu_rob", 32'(alu_rob_entry), 32'(e.rob));
            end
        end
    end

    initial begin
        mo = '{default: 0};
        for (int i = 0; i < RS; i++) m[i] = '{default: 0};
        rst_in = 0; rdy_in = 1; idle();
        issue_op = 0; issue_pc = 0; issue_imm = 0; issue_rob_entry = 0;
        issue_qi_valid = 0; issue_qj_valid = 0; issue_qi = 0; issue_qj = 0;
        issue_vi = 0; issue_vj = 0;
        cdb_alu_rob = 0; cdb_lsb_rob = 0; cdb_alu_val = 0; cdb_lsb_val = 0;
        @(negedge clk_in);

        // Reset, then quiet cycles
        tick(); tick();
        rst_in = 1;
        tick(); tick();

        // Ready BEQ
        issue(3'b000, 32'h100, 12'h004, 4'd3, 0, 0, 32'd5, 0, 0, 32'd5);
        tick(); idle(); tick(); tick(); tick();

        // Wakeup by LSB bus two cycles after issue
        issue(3'b100, 32'h200, 12'h010, 4'd1, 1, 4'd7, 32'd0, 0, 0, 32'd10);
        tick(); idle(); tick();
        cdb_lsb_valid = 1; cdb_lsb_rob = 7; cdb_lsb_val = 32'hFFFF_FFFF;
        tick(); idle(); tick(); tick();

        // Same-cycle issue bypass from ALU bus on both operands
        issue(3'b101, 32'h300, 12'h020, 4'd4, 1, 4'd5, 32'd0, 1, 4'd6, 32'd0);
        cdb_alu_valid = 1; cdb_alu_rob = 5; cdb_alu_val = 32'h1234;
        cdb_lsb_valid = 1; cdb_lsb_rob = 6; cdb_lsb_val = 32'h5678;
        tick(); idle(); tick(); tick();

        // Fill all slots on tag 2, one extra issue dropped, then broadcast
        for (int i = 0; i < RS + 1; i++) begin
            issue(3'(i), 32'h1000 + 32'(i * 4), 12'(i), 4'(i), 1, 4'd2, 32'd0, 0, 0, 32'(i));
            tick();
        end
        idle();
        cdb_alu_valid = 1; cdb_alu_rob = 2; cdb_alu_val = 32'hCAFE;
        tick(); idle();
        for (int i = 0; i < RS + 2; i++) tick();

        // Flush on the dispatch edge of the ready entry
        for (int i = 0; i < 3; i++) begin
            issue(3'b001, 32'h400 + 32'(i), 12'h1, 4'(8 + i), 1, 4'd9, 32'd0, 0, 0, 32'd1);
            tick();
        end
        issue(3'b110, 32'h500, 12'h2, 4'd12, 0, 0, 32'd3, 0, 0, 32'd4);
        tick(); idle();
        clear_in = 1;
        tick(); idle();
        cdb_alu_valid = 1; cdb_alu_rob = 9; cdb_alu_val = 32'h99;
        tick(); idle(); tick(); tick();

        // Pause while alu_valid is high
        issue(3'b111, 32'h600, 12'h3, 4'd1, 0, 0, 32'd7, 0, 0, 32'd8);
        tick();
        issue(3'b000, 32'h604, 12'h4, 4'd2, 1, 4'd3, 32'd0, 0, 0, 32'd9);
        tick(); idle();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            rand_cdb(); cdb_alu_valid = 1; cdb_alu_rob = 3;
            tick();
        end
        rdy_in = 1; idle();
        cdb_alu_valid = 1; cdb_alu_rob = 3; cdb_alu_val = 32'h33;
        tick(); idle(); tick(); tick();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            idle();
            rand_cdb();
            if ($urandom_range(0, 99) < 55 && (!model_full() || $urandom_range(0, 9) == 0))
                issue(3'($urandom), $urandom, 12'($urandom), 4'($urandom),
                      $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), $urandom);
            clear_in = ($urandom_range(0, 99) < 2);
            rdy_in   = ($urandom_range(0, 99) >= 10);
            rst_in   = ($urandom_range(0, 999) >= 5);
            tick();
        end
        rst_in = 1; rdy_in = 1; idle();
        tick(); tick();
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
